// File: rtl/replica_pkg.sv
// Shared scheduler types, limits and width helper for the replica-exchange node.
package replica_pkg;

    localparam int unsigned CH_NUM_MAX = 8;
    localparam int unsigned DRAIN_W    = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_EXCH   = 3'd3,
        ST_ROTATE = 3'd4
    } sched_state_t;

    // Selector width per channel; never narrower than one bit.
    function automatic int unsigned ch_log(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/base_rotator.sv
// Maps the rotation offset to per-channel replica base selectors: base_sel[i] = (i + rot) mod CH_NUM.
module base_rotator import replica_pkg::*; #(
    parameter  int unsigned CH_NUM = 2,
    localparam int unsigned CH_LOG = ch_log(CH_NUM)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [CH_LOG-1:0]        rot_i,
    output logic [CH_NUM*CH_LOG-1:0] base_sel_o
);

    logic [CH_NUM*CH_LOG-1:0] base_sel_d;
    int unsigned              sum;

    // rot_i is always below CH_NUM, so one conditional subtract is a full modulo.
    always_comb begin
        base_sel_d = '0;
        sum        = 0;
        for (int unsigned i = 0; i < CH_NUM; i++) begin
            sum = i + 32'(rot_i);
            if (sum >= CH_NUM) begin
                sum = sum - CH_NUM;
            end
            base_sel_d[i*CH_LOG +: CH_LOG] = CH_LOG'(sum);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < CH_NUM; i++) begin
                base_sel_o[i*CH_LOG +: CH_LOG] <= CH_LOG'(i);
            end
        end else begin
            base_sel_o <= base_sel_d;
        end
    end

endmodule

// File: rtl/node_sched.sv
// Epoch scheduler for one annealing node: run opt channels, drain the pipe, exchange replicas, rotate bases.
module node_sched import replica_pkg::*; #(
    parameter  int unsigned CH_NUM   = 2,
    parameter  int unsigned PIPE_LAT = 8,
    parameter  int unsigned ITER_W   = 16,
    localparam int unsigned CH_LOG   = ch_log(CH_NUM)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     opt_run,
    input  logic [CH_NUM-1:0]        ch_en,
    input  logic [ITER_W-1:0]        iter_num,
    input  logic                     ex_done,
    output logic [CH_NUM-1:0]        opt_en,
    output logic [CH_NUM*CH_LOG-1:0] base_sel,
    output logic                     ex_start,
    output logic                     ex_parity,
    output logic [ITER_W-1:0]        epoch_cnt,
    output logic                     busy
);

    sched_state_t        state_q, state_d;
    logic [ITER_W-1:0]   iter_q, iter_d;
    logic [DRAIN_W-1:0]  drain_q, drain_d;
    logic [CH_LOG-1:0]   rot_q, rot_d;
    logic                parity_q, parity_d;
    logic [ITER_W-1:0]   epoch_q, epoch_d;
    logic [CH_NUM-1:0]   opt_en_q, opt_en_d;
    logic                ex_start_q, ex_start_d;
    logic                busy_q, busy_d;
    logic                ch_any_c;
    logic [ITER_W-1:0]   iter_last_c;

    assign ch_any_c    = |ch_en;
    assign iter_last_c = (iter_num == '0) ? '0 : iter_num - ITER_W'(1);

    always_comb begin
        state_d  = state_q;
        iter_d   = iter_q;
        drain_d  = drain_q;
        rot_d    = rot_q;
        parity_d = parity_q;
        epoch_d  = epoch_q;
        case (state_q)
            ST_IDLE: begin
                if (opt_run && ch_any_c) begin
                    state_d = ST_RUN;
                    iter_d  = '0;
                end
            end
            ST_RUN: begin
                if (!opt_run || iter_q >= iter_last_c) begin
                    state_d = ST_DRAIN;
                    drain_d = '0;
                end else begin
                    iter_d = iter_q + ITER_W'(1);
                end
            end
            ST_DRAIN: begin
                if (drain_q == DRAIN_W'(PIPE_LAT - 1)) begin
                    state_d = ST_EXCH;
                end else begin
                    drain_d = drain_q + DRAIN_W'(1);
                end
            end
            ST_EXCH: begin
                if (ex_done) begin
                    state_d = ST_ROTATE;
                end
            end
            ST_ROTATE: begin
                rot_d    = (rot_q == CH_LOG'(CH_NUM - 1)) ? '0 : rot_q + CH_LOG'(1);
                parity_d = ~parity_q;
                if (epoch_q != {ITER_W{1'b1}}) begin
                    epoch_d = epoch_q + ITER_W'(1);
                end
                iter_d  = '0;
                state_d = (opt_run && ch_any_c) ? ST_RUN : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Outputs are precomputed from the next state so they land with it.
        opt_en_d   = (state_d == ST_RUN) ? ch_en : '0;
        ex_start_d = (state_d == ST_EXCH) && (state_q != ST_EXCH);
        busy_d     = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            iter_q     <= '0;
            drain_q    <= '0;
            rot_q      <= '0;
            parity_q   <= 1'b0;
            epoch_q    <= '0;
            opt_en_q   <= '0;
            ex_start_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            iter_q     <= iter_d;
            drain_q    <= drain_d;
            rot_q      <= rot_d;
            parity_q   <= parity_d;
            epoch_q    <= epoch_d;
            opt_en_q   <= opt_en_d;
            ex_start_q <= ex_start_d;
            busy_q     <= busy_d;
        end
    end

    base_rotator #(
        .CH_NUM (CH_NUM)
    ) u_base_rotator (
        .clk        (clk),
        .rst_n      (reset),
        .rot_i      (rot_d),
        .base_sel_o (base_sel)
    );

    assign opt_en    = opt_en_q;
    assign ex_start  = ex_start_q;
    assign ex_parity = parity_q;
    assign epoch_cnt = epoch_q;
    assign busy      = busy_q;

endmodule

// File: doc/node_sched.md
NODE_SCHED -- requirements
Module: node_sched

Interface
REQ-001 SHALL have parameter CH_NUM, default 2, number of opt sub-node channels per node (2..8).
REQ-002 SHALL have parameter PIPE_LAT, default 8, drain cycles for in-flight opt operations (1..255).
REQ-003 SHALL have parameter ITER_W, default 16, iteration counter width.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port opt_run  input  1  level request to run annealing epochs.
REQ-007 SHALL have port ch_en  input  CH_NUM  per-channel opt enable mask.
REQ-008 SHALL have port iter_num  input  ITER_W  opt iterations per epoch.
REQ-009 SHALL have port ex_done  input  1  one-cycle pulse: replica exchange finished.
REQ-010 SHALL have port opt_en  output  CH_NUM  per-channel opt issue enable.
REQ-011 SHALL have port base_sel  output  CH_NUM*CH_LOG  per-channel replica base selector, CH_LOG=max(1,clog2(CH_NUM)).
REQ-012 SHALL have port ex_start  output  1  one-cycle pulse starting replica exchange.
REQ-013 SHALL have port ex_parity  output  1  even(0)/odd(1) pair set for current exchange.
REQ-014 SHALL have port epoch_cnt  output  ITER_W  completed epochs, saturating.
REQ-015 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-016 SHALL implement states IDLE, RUN, DRAIN, EXCH, ROTATE.
REQ-017 IDLE -> RUN on the cycle after opt_run=1 and ch_en!=0; iteration counter cleared; otherwise stay IDLE.
REQ-018 RUN: opt_en=ch_en (sampled each cycle); iteration counter increments each cycle.
REQ-019 RUN -> DRAIN when counter reaches iter_num-1 (iter_num=0 treated as 1) or opt_run=0; opt_en=0 from DRAIN entry.
REQ-020 DRAIN: count exactly PIPE_LAT cycles, then -> EXCH.
REQ-021 EXCH entry: ex_start high exactly one cycle (first EXCH cycle); wait for ex_done; ex_done in any other state ignored.
REQ-022 ex_done arriving on the ex_start cycle SHALL be accepted.
REQ-023 EXCH -> ROTATE on ex_done; ROTATE lasts one cycle.
REQ-024 ROTATE: rot <= (rot+1) mod CH_NUM; ex_parity toggles; epoch_cnt increments, holding at all-ones.
REQ-025 ROTATE -> RUN (counter cleared) if opt_run=1 and ch_en!=0, else -> IDLE.
REQ-026 opt_run falling during DRAIN or EXCH SHALL NOT abort; epoch completes, then IDLE.
REQ-027 base_sel[i] SHALL equal (i+rot) mod CH_NUM, registered, updated the cycle after ROTATE.
REQ-028 ch_en going 0 during RUN: opt_en=0, state stays RUN until exit condition.

Reset
REQ-029 On reset low: state IDLE, opt_en=0, ex_start=0, ex_parity=0, epoch_cnt=0, rot=0, base_sel[i]=i, busy=0, counters 0.
REQ-030 Reset mid-operation SHALL abandon the epoch immediately with no ex_start emitted after release.

Structure
REQ-031 sched_state_t enum and CH_NUM_MAX=8 SHALL live in replica_pkg.
REQ-032 One sub-module, base_rotator (rot -> base_sel mapping, parameter CH_NUM), SHALL be instantiated.

Verification (CH_NUM=2, PIPE_LAT=4, iter_num=3)
REQ-033 opt_run=1, ch_en=2'b11 -> opt_en=2'b11 for exactly 3 cycles, ex_start 4 cycles after opt_en falls.
REQ-034 ex_done 2 cycles after ex_start -> epoch_cnt 0->1, ex_parity 0->1, base_sel {1,0}, RUN re-entered next cycle.
REQ-035 opt_run dropped during DRAIN -> ex_start still issued; after ex_done state IDLE, busy=0, epoch_cnt=1.
REQ-036 iter_num=0, ch_en=2'b01 -> opt_en=2'b01 for exactly 1 cycle.
REQ-037 reset low during EXCH -> all outputs at reset values; stray ex_done after release ignored, no ex_start.
REQ-038 CH_NUM=3, three epochs -> base_sel sequence {0,1,2},{1,2,0},{2,0,1},{0,1,2}.
